// File: rtl/encoder_4x2_hs_pkg.sv
// Shared definitions for the 4-to-2 handshake encoder: FSM states,
// line-to-code constants and the all-inactive line pattern.
package encoder_4x2_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        QUALIFY = 2'b01,
        VALID   = 2'b10,
        RELEASE = 2'b11
    } encState_e;

    // Lines are active-low, so an idle bus reads all ones.
    localparam logic [0:3] LINES_NONE = 4'b1111;

    localparam logic [1:0] CODE_LINE3 = 2'b11;
    localparam logic [1:0] CODE_LINE2 = 2'b10;
    localparam logic [1:0] CODE_LINE1 = 2'b01;
    localparam logic [1:0] CODE_LINE0 = 2'b00;

    // Wide enough for the largest stability requirement (15 samples).
    localparam int SCNT_W = 4;

endpackage

// File: rtl/encoder_4x2_hs_prio.sv
// Combinational priority encoder for an active-low 4-line vector.
// Line 3 has the highest priority; an empty pattern encodes as line 0
// and is flagged by any=0.
module priority_encoder_4x2
    import encoder_4x2_hs_pkg::*;
(
    input  logic [0:3] D,
    output logic       A,
    output logic       B,
    output logic       any,
    output logic       multi
);

    logic [0:3] active;
    logic [1:0] code;

    assign active = ~D;

    // Pick the code of the highest-numbered active line.
    always_comb begin
        code = CODE_LINE0;
        if (active[3]) begin
            code = CODE_LINE3;
        end else if (active[2]) begin
            code = CODE_LINE2;
        end else if (active[1]) begin
            code = CODE_LINE1;
        end
    end

    assign A     = code[1];
    assign B     = code[0];
    assign any   = |active;
    assign multi = (active[0] & active[1]) | (active[0] & active[2]) |
                   (active[0] & active[3]) | (active[1] & active[2]) |
                   (active[1] & active[3]) | (active[2] & active[3]);

endmodule

// File: rtl/encoder_4x2_hs.sv
// Registered 4-to-2 priority encoder with input qualification and a
// valid/ack handshake. A line pattern must hold for STABLE_CYCLES
// registered samples before its code is captured; the code is then held
// until acknowledged, and the input must go idle (or enable rise) before
// another pattern can be qualified.
module encoder_4x2_hs
    import encoder_4x2_hs_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [0:3]       D,
    input  logic             enable,
    input  logic             ack,
    output logic             A,
    output logic             B,
    output logic             valid,
    output logic             multi,
    output logic [CNT_W-1:0] count
);

    localparam logic [SCNT_W-1:0] STABLE_CNT = SCNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  COUNT_ONE  = CNT_W'(1);

    encState_e         state_q, state_d;
    logic [0:3]        d_q;
    logic [0:3]        cand_q, cand_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              capture;

    logic [0:3]        encIn;
    logic              encA, encB, encAny, encMulti;

    // In IDLE the encoder looks at the incoming sample so that a one-sample
    // requirement can capture on the same edge that loads the candidate;
    // everywhere else it encodes the held candidate.
    assign encIn = (state_q == IDLE) ? d_q : cand_q;

    priority_encoder_4x2 u_prio (
        .D     (encIn),
        .A     (encA),
        .B     (encB),
        .any   (encAny),
        .multi (encMulti)
    );

    // Input sample register; all qualification works from this copy.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            d_q <= LINES_NONE;
        end else begin
            d_q <= D;
        end
    end

    // FSM state, candidate, stability counter and output registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            cand_q  <= LINES_NONE;
            scnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            scnt_q  <= scnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: qualify, capture, wait for ack, then wait for the
    // bus to go idle so a held pattern is not captured twice.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        scnt_d  = scnt_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        multi_d = multi_q;
        count_d = count_q;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!enable && encAny) begin
                    cand_d = d_q;
                    scnt_d = SCNT_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        capture = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (enable || (d_q != cand_q)) begin
                    state_d = IDLE;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                    if ((scnt_q + SCNT_W'(1)) == STABLE_CNT) begin
                        capture = 1'b1;
                    end
                end
            end
            VALID: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if ((d_q == LINES_NONE) || enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            a_d     = encA;
            b_d     = encB;
            multi_d = encMulti;
            valid_d = 1'b1;
            count_d = count_q + COUNT_ONE;
            state_d = VALID;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign valid = valid_q;
    assign multi = multi_q;
    assign count = count_q;

endmodule

// File: tb/tb_encoder_4x2_hs.sv
// Self-checking bench for encoder_4x2_hs. Two instances share the inputs:
// one with the default two-sample qualification and one qualifying on a
// single sample; a select picks which one is being observed.
module tb_encoder_4x2_hs;

    typedef struct {
        logic [0:3] d;
        logic [1:0] ab;
        logic       m;
    } vec_t;

    logic       clock;
    logic       resetB;
    logic [0:3] dIn;
    logic       enable;
    logic       ack;

    logic       a2, b2, valid2, multi2;
    logic [3:0] count2;
    logic       a1, b1, valid1, multi1;
    logic [3:0] count1;

    logic       sel1;
    logic [1:0] obsAB;
    logic       obsValid;
    logic       obsMulti;
    logic [3:0] obsCount;

    int         checks;
    int         failures;
    logic [3:0] expCount;
    vec_t       vecs[8];

    encoder_4x2_hs #(.STABLE_CYCLES(2), .CNT_W(4)) dut (
        .clock   (clock),
        .reset_b (resetB),
        .D       (dIn),
        .enable  (enable),
        .ack     (ack),
        .A       (a2),
        .B       (b2),
        .valid   (valid2),
        .multi   (multi2),
        .count   (count2)
    );

    encoder_4x2_hs #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clock   (clock),
        .reset_b (resetB),
        .D       (dIn),
        .enable  (enable),
        .ack     (ack),
        .A       (a1),
        .B       (b1),
        .valid   (valid1),
        .multi   (multi1),
        .count   (count1)
    );

    assign obsAB    = sel1 ? {a1, b1} : {a2, b2};
    assign obsValid = sel1 ? valid1 : valid2;
    assign obsMulti = sel1 ? multi1 : multi2;
    assign obsCount = sel1 ? count1 : count2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [0:3] d, input logic en, input logic ak);
        dIn    = d;
        enable = en;
        ack    = ak;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        resetB = 1'b0;
        tick(2);
        checkOutput("reset_valid", int'(obsValid), 0);
        checkOutput("reset_code", int'(obsAB), 0);
        checkOutput("reset_multi", int'(obsMulti), 0);
        checkOutput("reset_count", int'(obsCount), 0);
        resetB = 1'b1;
        tick(1);
        expCount = 4'd0;
    endtask

    // Present a pattern from IDLE and expect the capture after lat edges.
    task automatic captureAndCheck(input logic [0:3] pat, input logic [1:0] ab,
                                   input logic m, input int lat);
        applyStimulus(pat, 1'b0, 1'b0);
        tick(lat - 1);
        checkOutput("valid_early", int'(obsValid), 0);
        tick(1);
        expCount = expCount + 4'd1;
        checkOutput("valid_rise", int'(obsValid), 1);
        checkOutput("code", int'(obsAB), int'(ab));
        checkOutput("multi", int'(obsMulti), int'(m));
        checkOutput("count", int'(obsCount), int'(expCount));
    endtask

    // Acknowledge with D still held, confirm no re-capture, then idle the bus.
    task automatic releaseAndCheck(input logic [0:3] pat, input int lat);
        applyStimulus(pat, 1'b0, 1'b1);
        tick(1);
        checkOutput("valid_fall", int'(obsValid), 0);
        tick(lat + 3);
        checkOutput("no_recapture", int'(obsValid), 0);
        checkOutput("count_held", int'(obsCount), int'(expCount));
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick(2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel1     = 1'b0;
        expCount = 4'd0;
        applyStimulus(4'b1111, 1'b1, 1'b0);
        resetB = 1'b0;

        vecs[0] = '{d: 4'b1101, ab: 2'b10, m: 1'b0};
        vecs[1] = '{d: 4'b0110, ab: 2'b11, m: 1'b1};
        vecs[2] = '{d: 4'b1110, ab: 2'b11, m: 1'b0};
        vecs[3] = '{d: 4'b1011, ab: 2'b01, m: 1'b0};
        vecs[4] = '{d: 4'b0111, ab: 2'b00, m: 1'b0};
        vecs[5] = '{d: 4'b0011, ab: 2'b01, m: 1'b1};
        vecs[6] = '{d: 4'b1000, ab: 2'b11, m: 1'b1};
        vecs[7] = '{d: 4'b0101, ab: 2'b10, m: 1'b1};

        doReset();

        // Table-driven capture/ack cycles, two-sample qualification.
        for (int i = 0; i < 8; i++) begin
            captureAndCheck(vecs[i].d, vecs[i].ab, vecs[i].m, 3);
            if (i == 0) begin
                // While VALID, D and enable are ignored.
                applyStimulus(4'b0000, 1'b1, 1'b0);
                tick(2);
                checkOutput("frozen_valid", int'(obsValid), 1);
                checkOutput("frozen_code", int'(obsAB), int'(vecs[i].ab));
                checkOutput("frozen_multi", int'(obsMulti), int'(vecs[i].m));
            end
            releaseAndCheck(vecs[i].d, 3);
        end

        // One-sample glitch on line 1 never qualifies.
        applyStimulus(4'b1011, 1'b0, 1'b0);
        tick(1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick(5);
        checkOutput("glitch_valid", int'(obsValid), 0);
        checkOutput("glitch_count", int'(obsCount), int'(expCount));

        // enable high blocks qualification; dropping it lets the held pattern through.
        applyStimulus(4'b0111, 1'b1, 1'b0);
        tick(4);
        checkOutput("enable_block", int'(obsValid), 0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        tick(1);
        checkOutput("enable_drop_early", int'(obsValid), 0);
        tick(1);
        expCount = expCount + 4'd1;
        checkOutput("enable_drop_valid", int'(obsValid), 1);
        checkOutput("enable_drop_code", int'(obsAB), 0);
        releaseAndCheck(4'b0111, 3);

        // Raising enable mid-qualify aborts the pending capture.
        applyStimulus(4'b1110, 1'b0, 1'b0);
        tick(2);
        applyStimulus(4'b1110, 1'b1, 1'b0);
        tick(3);
        checkOutput("abort_valid", int'(obsValid), 0);
        checkOutput("abort_count", int'(obsCount), int'(expCount));
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick(2);

        // Asynchronous reset during VALID discards the code.
        captureAndCheck(4'b0111, 2'b00, 1'b0, 3);
        #2;
        resetB = 1'b0;
        #1;
        checkOutput("async_rst_valid", int'(obsValid), 0);
        checkOutput("async_rst_count", int'(obsCount), 0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick(1);
        resetB = 1'b1;
        tick(1);
        expCount = 4'd0;
        checkOutput("post_rst_valid", int'(obsValid), 0);
        captureAndCheck(4'b1101, 2'b10, 1'b0, 3);
        releaseAndCheck(4'b1101, 3);

        // Sixteen captures wrap the 4-bit counter back to 0.
        doReset();
        for (int i = 0; i < 16; i++) begin
            captureAndCheck(vecs[i % 8].d, vecs[i % 8].ab, vecs[i % 8].m, 3);
            releaseAndCheck(vecs[i % 8].d, 3);
        end
        checkOutput("count_wrap", int'(obsCount), 0);

        // Single-sample qualification: two-edge latency.
        sel1 = 1'b1;
        doReset();
        for (int i = 0; i < 3; i++) begin
            captureAndCheck(vecs[i].d, vecs[i].ab, vecs[i].m, 2);
            releaseAndCheck(vecs[i].d, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
